// File: rtl/fix_div_pkg.sv
// fix_div_pkg: shared definitions for the fix_div_hs sign-magnitude divider.
//   - FSM state encoding (IDLE, CALC, RND, DONE)
//   - sizing helpers: iteration count, remainder width, counter width
//   - saturation constant builder (all-ones mask of a given width)
package fix_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RND  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Upper bound for the width of masks produced by sat_f.
  localparam int MAX_W = 256;

  // Number of CALC cycles needed to resolve all N-1+Q quotient bits.
  function automatic int iter_f(input int n, input int q, input int bpc);
    return (n - 1 + q) / bpc;
  endfunction

  // Remainder never exceeds the divisor magnitude, so N bits leave one bit
  // of headroom for the shifted-in dividend bit.
  function automatic int rem_w_f(input int n);
    return n;
  endfunction

  // Width of the iteration down-counter (must hold iter-1).
  function automatic int cnt_w_f(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  // All-ones mask of width w, right-aligned in a MAX_W vector.
  function automatic logic [MAX_W-1:0] sat_f(input int w);
    logic [MAX_W-1:0] m;
    m = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      m[i] = (i < w) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/fix_div_hs_if.sv
// fix_div_hs_if: operand/result handshake bundle of the fix_div_hs divider.
//   Operand side : i_valid, o_ready, i_dividend, i_divisor, i_round
//   Result side  : o_valid, i_ready, o_quotient_int, o_quotient_frac, o_dbz
//   master = producer/consumer around the divider, slave = the divider.
interface fix_div_hs_if #(
  parameter int N = 33,
  parameter int Q = 33
);
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         i_round;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_quotient_int;
  logic [Q-1:0] o_quotient_frac;
  logic         o_dbz;

  modport master (
    output i_valid, i_dividend, i_divisor, i_round, i_ready,
    input  o_ready, o_valid, o_quotient_int, o_quotient_frac, o_dbz
  );

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_round, i_ready,
    output o_ready, o_valid, o_quotient_int, o_quotient_frac, o_dbz
  );
endinterface

// File: rtl/fix_div_step.sv
// fix_div_step: one combinational restoring-division step.
//   rem     : current partial remainder (always below div)
//   div     : divisor magnitude
//   nbit    : next dividend bit shifted into the remainder
//   rem_nxt : updated remainder
//   qbit    : resolved quotient bit
module fix_div_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] div,
  input  logic         nbit,
  output logic [W-1:0] rem_nxt,
  output logic         qbit
);

  logic [W:0] trial_s;

  // Shift in the next bit, subtract the divisor when it fits.
  always_comb begin
    trial_s = {rem, nbit};
    if (trial_s >= {1'b0, div}) begin
      qbit    = 1'b1;
      // The true difference is below div, so the low W bits are exact.
      rem_nxt = trial_s[W-1:0] - div;
    end else begin
      qbit    = 1'b0;
      rem_nxt = trial_s[W-1:0];
    end
  end

endmodule

// File: rtl/fix_div_hs.sv
// fix_div_hs: iterative sign-magnitude fixed-point divider, BPC quotient bits
// per cycle, optional round-half-up, divide-by-zero saturation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fix_div_hs_if.slave (operand and result handshakes)
// The dividend magnitude (with Q zero LSBs appended) and the growing quotient
// share one shift register: dividend bits leave at the MSB while quotient
// bits enter at the LSB, so after the last CALC cycle it holds the quotient.
module fix_div_hs
  import fix_div_pkg::*;
#(
  parameter int N   = 33,
  parameter int Q   = 33,
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  fix_div_hs_if.slave  bus
);

  localparam int QW   = N - 1 + Q;
  localparam int ITER = iter_f(N, Q, BPC);
  localparam int RW   = rem_w_f(N);
  localparam int CW   = cnt_w_f(ITER);
  localparam logic [CW-1:0]    CNT_INIT = CW'(ITER - 1);
  localparam logic [MAX_W-1:0] SAT_FULL = sat_f(QW);
  localparam logic [QW-1:0]    SAT_Q    = SAT_FULL[QW-1:0];

  if ((N - 1 + Q) % BPC != 0) begin : g_bpc_check
    $error("fix_div_hs: N-1+Q must be a multiple of BPC");
  end

  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [RW-1:0] rem_r, rem_nxt_s;
  logic [QW-1:0] dq_r, dq_nxt_s;
  logic [RW-1:0] div_r, div_nxt_s;
  logic          sign_r, sign_nxt_s;
  logic          round_r, round_nxt_s;
  logic          ready_r, valid_r, dbz_r;
  logic [N-1:0]  qint_r;
  logic [Q-1:0]  qfrac_r;

  logic          load_s;
  logic [QW-1:0] fin_q_s;
  logic          fin_sign_s, fin_dbz_s, out_sign_s;
  logic [RW-1:0] div_mag_s;
  logic          first_bit_s;
  logic [BPC-1:0] qv_s;
  logic [QW-1:0] dq_shift_s;
  logic [RW-1:0] rem_last_s;
  logic          guard_s;

  assign div_mag_s   = {1'b0, bus.i_divisor[N-2:0]};
  // In RND the guard step shifts in an extended zero instead of a quotient bit.
  assign first_bit_s = (state_r == ST_RND) ? 1'b0 : dq_r[QW-1];

  for (genvar k = 0; k < BPC; k++) begin : g_step
    logic [RW-1:0] rem_prev_s;
    logic [RW-1:0] rem_next_s;
    logic          bit_s;
    if (k == 0) begin : g_first
      assign rem_prev_s = rem_r;
      assign bit_s      = first_bit_s;
    end else begin : g_rest
      assign rem_prev_s = g_step[k-1].rem_next_s;
      assign bit_s      = dq_r[QW-1-k];
    end
    fix_div_step #(.W(RW)) u_step (
      .rem     (rem_prev_s),
      .div     (div_r),
      .nbit    (bit_s),
      .rem_nxt (rem_next_s),
      .qbit    (qv_s[BPC-1-k])
    );
  end

  assign rem_last_s = g_step[BPC-1].rem_next_s;
  assign guard_s    = qv_s[BPC-1];

  if (BPC < QW) begin : g_shift
    assign dq_shift_s = {dq_r[QW-BPC-1:0], qv_s};
  end else begin : g_shift_all
    assign dq_shift_s = qv_s;
  end

  // Next-state, datapath update and final-result selection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rem_nxt_s   = rem_r;
    dq_nxt_s    = dq_r;
    div_nxt_s   = div_r;
    sign_nxt_s  = sign_r;
    round_nxt_s = round_r;
    load_s      = 1'b0;
    fin_q_s     = dq_r;
    fin_sign_s  = sign_r;
    fin_dbz_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_valid) begin
          sign_nxt_s  = bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
          round_nxt_s = bus.i_round;
          div_nxt_s   = div_mag_s;
          rem_nxt_s   = {RW{1'b0}};
          dq_nxt_s    = {bus.i_dividend[N-2:0], {Q{1'b0}}};
          cnt_nxt_s   = CNT_INIT;
          if (div_mag_s == {RW{1'b0}}) begin
            state_nxt_s = ST_DONE;
            load_s      = 1'b1;
            fin_q_s     = SAT_Q;
            fin_sign_s  = bus.i_dividend[N-1];
            fin_dbz_s   = 1'b1;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        rem_nxt_s = rem_last_s;
        dq_nxt_s  = dq_shift_s;
        if (cnt_r == {CW{1'b0}}) begin
          if (round_r) begin
            state_nxt_s = ST_RND;
          end else begin
            state_nxt_s = ST_DONE;
            load_s      = 1'b1;
            fin_q_s     = dq_shift_s;
          end
        end else begin
          cnt_nxt_s = cnt_r - CW'(1'b1);
        end
      end
      ST_RND: begin
        state_nxt_s = ST_DONE;
        load_s      = 1'b1;
        if (guard_s) begin
          if (dq_r == SAT_Q) begin
            fin_q_s = dq_r;
          end else begin
            fin_q_s = dq_r + QW'(1'b1);
          end
        end else begin
          fin_q_s = dq_r;
        end
        dq_nxt_s = fin_q_s;
      end
      ST_DONE: begin
        if (bus.i_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // A zero magnitude never carries a negative sign.
  assign out_sign_s = fin_sign_s & (|fin_q_s);

  // FSM and division datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      rem_r   <= {RW{1'b0}};
      dq_r    <= {QW{1'b0}};
      div_r   <= {RW{1'b0}};
      sign_r  <= 1'b0;
      round_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rem_r   <= rem_nxt_s;
      dq_r    <= dq_nxt_s;
      div_r   <= div_nxt_s;
      sign_r  <= sign_nxt_s;
      round_r <= round_nxt_s;
    end
  end

  // Registered handshake flags and result hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      dbz_r   <= 1'b0;
      qint_r  <= {N{1'b0}};
      qfrac_r <= {Q{1'b0}};
    end else begin
      ready_r <= (state_nxt_s == ST_IDLE);
      valid_r <= (state_nxt_s == ST_DONE);
      if (load_s) begin
        dbz_r   <= fin_dbz_s;
        qint_r  <= {out_sign_s, fin_q_s[QW-1:Q]};
        qfrac_r <= fin_q_s[Q-1:0];
      end else begin
        dbz_r   <= dbz_r;
        qint_r  <= qint_r;
        qfrac_r <= qfrac_r;
      end
    end
  end

  assign bus.o_ready         = ready_r;
  assign bus.o_valid         = valid_r;
  assign bus.o_dbz           = dbz_r;
  assign bus.o_quotient_int  = qint_r;
  assign bus.o_quotient_frac = qfrac_r;

endmodule

// File: tb/tb_fix_div_hs.sv
// tb_fix_div_hs: scoreboard bench for fix_div_hs with N=8, Q=5.
// Two instances (BPC=1 and BPC=3) receive identical operands; each has its
// own expected-result queue filled on accept and drained by its monitor.
module tb_fix_div_hs;

  localparam int N  = 8;
  localparam int Q  = 5;
  localparam int QW = N - 1 + Q;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit sb_en = 1'b1;
  int hold_req = 0;

  logic       iv   [2];
  logic [7:0] ia   [2];
  logic [7:0] ib   [2];
  logic       ir   [2];
  logic       ord  [2];
  logic       ov   [2];
  logic       odbz [2];
  logic [7:0] oqi  [2];
  logic [4:0] oqf  [2];

  typedef struct {
    logic [7:0] qi;
    logic [4:0] qf;
    logic       dbz;
    int         lat;
    int         acc;
    int         hold;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: quotient = floor(|a| * 2^Q / |b|); rounding adds the next
  // binary digit of the exact quotient. Latency counts from the cycle the
  // operands are presented to the first cycle o_valid is high.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic r, input int iter);
    exp_t e;
    int ma, mb, qm, maxq;
    logic s;
    ma   = int'(a[6:0]);
    mb   = int'(b[6:0]);
    maxq = (1 << QW) - 1;
    if (mb == 0) begin
      qm    = maxq;
      s     = a[7];
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      qm = (ma << Q) / mb;
      if (r) qm = qm + (((ma << (Q + 1)) / mb) % 2);
      if (qm > maxq) qm = maxq;
      s     = a[7] ^ b[7];
      e.dbz = 1'b0;
      e.lat = iter + 1 + (r ? 1 : 0);
    end
    if (qm == 0) s = 1'b0;
    e.qi   = {s, 7'(qm >> Q)};
    e.qf   = 5'(qm % 32);
    e.acc  = 0;
    e.hold = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int BPC_G  = (g == 0) ? 1 : 3;
    localparam int ITER_G = (N - 1 + Q) / BPC_G;

    fix_div_hs_if #(.N(N), .Q(Q)) bus ();
    logic rdy;
    exp_t sbq[$];
    int   pend;

    assign bus.i_valid    = iv[g];
    assign bus.i_dividend = ia[g];
    assign bus.i_divisor  = ib[g];
    assign bus.i_round    = ir[g];
    assign bus.i_ready    = rdy;
    assign ord[g]  = bus.o_ready;
    assign ov[g]   = bus.o_valid;
    assign odbz[g] = bus.o_dbz;
    assign oqi[g]  = bus.o_quotient_int;
    assign oqf[g]  = bus.o_quotient_frac;

    fix_div_hs #(.N(N), .Q(Q), .BPC(BPC_G)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    initial begin : mon
      exp_t e;
      bit first;
      bit took;
      int hold_cnt;
      first = 1'b1;
      took = 1'b0;
      hold_cnt = 0;
      rdy = 1'b0;
      pend = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          rdy = 1'b0;
          first = 1'b1;
          took = 1'b0;
        end else begin
          if (ov[g]) begin
            if (sbq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected_valid: got o_valid=1 required no pending result", g);
              rdy = 1'b0;
            end else begin
              e = sbq[0];
              if (first) begin
                chk($sformatf("dut%0d latency", g), 32'(cyc - e.acc), 32'(e.lat));
                first = 1'b0;
                hold_cnt = 0;
              end
              chk($sformatf("dut%0d qint", g), 32'(oqi[g]), 32'(e.qi));
              chk($sformatf("dut%0d qfrac", g), 32'(oqf[g]), 32'(e.qf));
              chk($sformatf("dut%0d dbz", g), 32'(odbz[g]), 32'(e.dbz));
              chk($sformatf("dut%0d ready_in_done", g), 32'(ord[g]), 32'd0);
              if (hold_cnt >= e.hold) begin
                rdy = 1'b1;
                void'(sbq.pop_front());
                first = 1'b1;
                took = 1'b1;
              end else begin
                rdy = 1'b0;
                hold_cnt++;
              end
            end
          end else begin
            if (took) chk($sformatf("dut%0d ready_after_take", g), 32'(ord[g]), 32'd1);
            took = 1'b0;
            rdy = 1'b0;
          end
          if (sb_en && iv[g] && ord[g]) begin
            e = model(ia[g], ib[g], ir[g], ITER_G);
            e.acc = cyc;
            e.hold = hold_req;
            sbq.push_back(e);
          end
        end
        pend = sbq.size();
      end
    end
  end

  task automatic check_reset(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s dut%0d o_ready", tag, g), 32'(ord[g]), 32'd1);
      chk($sformatf("%s dut%0d o_valid", tag, g), 32'(ov[g]), 32'd0);
      chk($sformatf("%s dut%0d o_dbz", tag, g), 32'(odbz[g]), 32'd0);
      chk($sformatf("%s dut%0d qint", tag, g), 32'(oqi[g]), 32'd0);
      chk($sformatf("%s dut%0d qfrac", tag, g), 32'(oqf[g]), 32'd0);
    end
  endtask

  // Waits for both dividers to be idle, jamming ignored garbage into busy ones.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic r, input int h);
    int waitc;
    waitc = 0;
    @(posedge clk); #2;
    while (!(ord[0] && ord[1]) && waitc < 500) begin
      for (int g = 0; g < 2; g++) begin
        if (ord[g]) begin
          iv[g] = 1'b0;
        end else begin
          iv[g] = 1'($urandom % 2);
          ia[g] = 8'($urandom);
          ib[g] = 8'($urandom);
          ir[g] = 1'($urandom % 2);
        end
      end
      @(posedge clk); #2;
      waitc++;
    end
    if (!(ord[0] && ord[1])) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got o_ready=%0b%0b required 11", ord[0], ord[1]);
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      return;
    end
    hold_req = h;
    for (int g = 0; g < 2; g++) begin
      iv[g] = 1'b1;
      ia[g] = a;
      ib[g] = b;
      ir[g] = r;
    end
    @(posedge clk); #2;
    iv[0] = 1'b0;
    iv[1] = 1'b0;
  endtask

  task automatic wait_drain();
    int waitc;
    waitc = 0;
    while ((g_dut[0].pend != 0 || g_dut[1].pend != 0) && waitc < 2000) begin
      @(posedge clk);
      waitc++;
    end
    if (g_dut[0].pend != 0 || g_dut[1].pend != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending=%0d,%0d required 0,0", g_dut[0].pend, g_dut[1].pend);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a, b;
    for (int g = 0; g < 2; g++) begin
      iv[g] = 1'b0;
      ia[g] = 8'h00;
      ib[g] = 8'h00;
      ir[g] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    issue(8'h0A, 8'h03, 1'b0, 0);
    issue(8'h0A, 8'h03, 1'b1, 0);
    issue(8'h87, 8'h02, 1'b0, 1);
    issue(8'h05, 8'h80, 1'b0, 0);
    issue(8'h80, 8'h05, 1'b0, 2);
    issue(8'h33, 8'h85, 1'b1, 5);
    issue(8'hFF, 8'h01, 1'b1, 0);
    wait_drain();

    // Abort a division mid-CALC; no result may ever appear for it.
    sb_en = 1'b0;
    issue(8'h0A, 8'h03, 1'b0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("midop");
    @(posedge clk);
    #2 rst_n = 1'b1;
    sb_en = 1'b1;

    issue(8'h02, 8'h03, 1'b1, 0);

    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom % 6 == 0) b[6:0] = 7'd0;
      issue(a, b, 1'($urandom % 2), int'($urandom_range(0, 3)));
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
